// File: rtl/issue_scheduler.sv
// ----------------------------------------------------------------------------
// issue_scheduler
//   Decode/issue-stage controller sitting right after the opcode decoder.
//   Tracks in-flight register writes in a per-register scoreboard, stalls on
//   RAW/WAW hazards, holds issue while a multi-cycle MUL/DIV occupies the ALU,
//   and injects NOP bubbles after a taken branch/jump flush.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     decoded instruction handshake (o_ready combinational)
//   i_rs1/2, i_rs1/2_en   source operands and their read enables
//   i_rd, i_rd_en         destination register and write enable
//   i_is_mul, i_is_div    multi-cycle ALU op (never both high)
//   i_wb_valid, i_wb_rd   retire strobe and the register it releases
//   i_flush               taken branch/jump, squash younger work
//   o_issue               instruction fires this cycle
//   o_nop                 bubble request to the decoder (= !o_issue)
//   o_stall_hz            valid instruction blocked by a scoreboard hazard
//   o_busy                ALU occupied by MUL/DIV
//   o_pending             scoreboard vector, one bit per register
//
// state  | meaning
// S_RUN  | issuing, one instruction per cycle when hazard free
// S_BUSY | MUL/DIV occupies the ALU, cnt counts remaining stall cycles
// S_FLUSH| injecting bubbles after a flush, cnt counts remaining bubbles
// ----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int NUM_REG      = 32,
    parameter int MUL_LAT      = 3,
    parameter int DIV_LAT      = 8,
    parameter int FLUSH_CYCLES = 2,
    localparam int REG_SELECT  = $clog2(NUM_REG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [REG_SELECT-1:0] i_rs1,
    input  logic [REG_SELECT-1:0] i_rs2,
    input  logic                  i_rs1_en,
    input  logic                  i_rs2_en,
    input  logic [REG_SELECT-1:0] i_rd,
    input  logic                  i_rd_en,
    input  logic                  i_is_mul,
    input  logic                  i_is_div,
    input  logic                  i_wb_valid,
    input  logic [REG_SELECT-1:0] i_wb_rd,
    input  logic                  i_flush,
    output logic                  o_issue,
    output logic                  o_nop,
    output logic                  o_stall_hz,
    output logic                  o_busy,
    output logic [NUM_REG-1:0]    o_pending
);

    localparam int MAX_LAT_A = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MAX_LAT   = (MAX_LAT_A > FLUSH_CYCLES) ? MAX_LAT_A : FLUSH_CYCLES;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    // Load values chosen so that exactly LAT-1 stall cycles (or FLUSH_CYCLES
    // bubbles) follow the cycle that entered the state.
    localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'((DIV_LAT > 1) ? (DIV_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REG-1:0]   pending_q, pending_d;

    logic busy_rs1, busy_rs2, busy_rd;
    logic hz;
    logic issue;

    // A retire in the same cycle releases the register early (forwarding).
    assign busy_rs1 = pending_q[i_rs1] & ~(i_wb_valid & (i_wb_rd == i_rs1));
    assign busy_rs2 = pending_q[i_rs2] & ~(i_wb_valid & (i_wb_rd == i_rs2));
    assign busy_rd  = pending_q[i_rd]  & ~(i_wb_valid & (i_wb_rd == i_rd));

    assign hz = (i_rs1_en & busy_rs1) | (i_rs2_en & busy_rs2) | (i_rd_en & busy_rd);

    assign o_ready    = ~i_rst & (state_q == S_RUN) & ~hz & ~i_flush;
    assign issue      = i_valid & o_ready;
    assign o_issue    = issue;
    assign o_nop      = ~issue;
    assign o_stall_hz = ~i_rst & i_valid & (state_q == S_RUN) & hz;
    assign o_busy     = ~i_rst & (state_q == S_BUSY);
    assign o_pending  = pending_q;

    // Scoreboard: clear on retire first, so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        if (i_wb_valid) begin
            pending_d[i_wb_rd] = 1'b0;
        end
        if (issue && i_rd_en && (i_rd != '0)) begin
            pending_d[i_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (issue && i_is_mul && (MUL_LAT > 1)) begin
                    state_d = S_BUSY;
                    cnt_d   = MUL_CNT;
                end else if (issue && i_is_div && (DIV_LAT > 1)) begin
                    state_d = S_BUSY;
                    cnt_d   = DIV_CNT;
                end
            end
            S_BUSY, S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
        // Flush overrides everything, including BUSY completion and a
        // restart while already flushing.
        if (i_flush) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_CNT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    logic        rs1_en, rs2_en, rd_en;
    logic        is_mul, is_div;
    logic        wb_valid;
    logic        flush;
    logic        issue, nop, stall_hz, busy;
    logic [31:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        ready;
        logic        issue;
        logic        stall;
        logic        busy;
        logic [31:0] pend;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   step = 0;

    issue_scheduler #(
        .NUM_REG(32), .MUL_LAT(3), .DIV_LAT(8), .FLUSH_CYCLES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_rs1(rs1), .i_rs2(rs2), .i_rs1_en(rs1_en), .i_rs2_en(rs2_en),
        .i_rd(rd), .i_rd_en(rd_en), .i_is_mul(is_mul), .i_is_div(is_div),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
        .o_issue(issue), .o_nop(nop), .o_stall_hz(stall_hz), .o_busy(busy),
        .o_pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int st, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, st, act, exp);
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready",   e.step, {31'd0, ready},    {31'd0, e.ready});
                chk("issue",   e.step, {31'd0, issue},    {31'd0, e.issue});
                chk("nop",     e.step, {31'd0, nop},      {31'd0, ~e.issue});
                chk("stall",   e.step, {31'd0, stall_hz}, {31'd0, e.stall});
                chk("busy",    e.step, {31'd0, busy},     {31'd0, e.busy});
                chk("pending", e.step, pending,           e.pend);
            end
        end
    end

    task automatic idle();
        valid = 0; rs1 = 0; rs2 = 0; rd = 0; rs1_en = 0; rs2_en = 0; rd_en = 0;
        is_mul = 0; is_div = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic ins(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d, input logic den);
        valid = 1; rs1 = r1; rs2 = r2; rs1_en = (r1 != 0); rs2_en = (r2 != 0); rd = d; rd_en = den;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1; wb_rd = r;
    endtask

    // Push the expectation for the current cycle, then advance one cycle.
    task automatic expect_cyc(input logic r, input logic s, input logic b, input logic [31:0] p);
        exp_t e;
        e.ready = r; e.issue = valid & r; e.stall = s; e.busy = b; e.pend = p; e.step = step;
        exp_q.push_back(e);
        step++;
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        // reset held with a valid instruction present
        ins(1, 2, 4, 1); expect_cyc(0, 0, 0, 32'h0);
        ins(1, 2, 4, 1); expect_cyc(0, 0, 0, 32'h0);
        rst = 0;
        // RAW on r5 with forwarded retire
        ins(1, 2, 5, 1);            expect_cyc(1, 0, 0, 32'h0000_0000);
        ins(5, 0, 0, 0);            expect_cyc(0, 1, 0, 32'h0000_0020);
        ins(5, 0, 0, 0);            expect_cyc(0, 1, 0, 32'h0000_0020);
        ins(5, 0, 6, 1); wb(5);     expect_cyc(1, 0, 0, 32'h0000_0020);
        ins(0, 0, 7, 1); wb(6);     expect_cyc(1, 0, 0, 32'h0000_0040);
        // same-cycle set and clear of r7: set wins
        ins(0, 0, 7, 1); wb(7);     expect_cyc(1, 0, 0, 32'h0000_0080);
        ins(0, 0, 0, 1); wb(7);     expect_cyc(1, 0, 0, 32'h0000_0080);
        // rd=0 never marked
                                    expect_cyc(1, 0, 0, 32'h0000_0000);
        // WAW on r3
        ins(0, 0, 3, 1);            expect_cyc(1, 0, 0, 32'h0000_0000);
        ins(0, 0, 3, 1);            expect_cyc(0, 1, 0, 32'h0000_0008);
        ins(0, 0, 3, 1); wb(3);     expect_cyc(1, 0, 0, 32'h0000_0008);
        wb(3);                      expect_cyc(1, 0, 0, 32'h0000_0008);
        // DIV: 7 busy cycles
        ins(0, 0, 0, 0); is_div = 1; expect_cyc(1, 0, 0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            ins(0, 0, 0, 0);        expect_cyc(0, 0, 1, 32'h0);
        end
        ins(0, 0, 0, 0);            expect_cyc(1, 0, 0, 32'h0);
        // MUL: 2 busy cycles
        ins(0, 0, 0, 0); is_mul = 1; expect_cyc(1, 0, 0, 32'h0);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 1, 32'h0);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 1, 32'h0);
        ins(0, 0, 0, 0);            expect_cyc(1, 0, 0, 32'h0);
        // DIV writing r9, flushed at cnt=4
        ins(0, 0, 9, 1); is_div = 1; expect_cyc(1, 0, 0, 32'h0);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 1, 32'h0000_0200);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 1, 32'h0000_0200);
        ins(0, 0, 0, 0); flush = 1; expect_cyc(0, 0, 1, 32'h0000_0200);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 0, 32'h0000_0200);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 0, 32'h0000_0200);
        ins(0, 0, 0, 0);            expect_cyc(1, 0, 0, 32'h0000_0200);
        // build pending 0x60, then flush in RUN and restart during FLUSH
        ins(0, 0, 5, 1); wb(9);     expect_cyc(1, 0, 0, 32'h0000_0200);
        ins(0, 0, 6, 1);            expect_cyc(1, 0, 0, 32'h0000_0020);
        ins(0, 0, 0, 0); flush = 1; expect_cyc(0, 0, 0, 32'h0000_0060);
        ins(0, 0, 0, 0); flush = 1; expect_cyc(0, 0, 0, 32'h0000_0060);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 0, 32'h0000_0060);
        ins(0, 0, 0, 0);            expect_cyc(0, 0, 0, 32'h0000_0060);
        ins(0, 0, 0, 0);            expect_cyc(1, 0, 0, 32'h0000_0060);
        // reset in the middle of FLUSH
        ins(0, 0, 0, 0); flush = 1; expect_cyc(0, 0, 0, 32'h0000_0060);
        rst = 1;
        ins(5, 0, 0, 0);            expect_cyc(0, 0, 0, 32'h0000_0060);
        rst = 1;
        ins(5, 0, 0, 0);            expect_cyc(0, 0, 0, 32'h0000_0000);
        rst = 0;
        ins(5, 0, 0, 0);            expect_cyc(1, 0, 0, 32'h0000_0000);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Decode/issue-stage controller placed directly after the opcode decoder.
- Keeps a per-register scoreboard of in-flight writes and stalls on read-after-write and write-after-write hazards.
- Holds issue while a multi-cycle MUL/DIV occupies the ALU, and injects NOP bubbles after a taken branch/jump flush.
- Drives the decoder's NOP input and the issue handshake toward fetch.

Parameters:
- NUM_REG, 32, architectural register count; REG_SELECT = $clog2(NUM_REG).
- MUL_LAT, 3, ALU occupancy in cycles for MUL (>=1).
- DIV_LAT, 8, ALU occupancy in cycles for DIV (>=1).
- FLUSH_CYCLES, 2, bubbles injected after a flush (>=1).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  decoded instruction present.
- o_ready  out  1  scheduler accepts the instruction this cycle.
- i_rs1 / i_rs2  in  REG_SELECT each  source registers.
- i_rs1_en / i_rs2_en  in  1 each  source is read.
- i_rd  in  REG_SELECT  destination register.
- i_rd_en  in  1  instruction writes i_rd (decoder is_write).
- i_is_mul / i_is_div  in  1 each  alu_op is MUL / DIV; never both high.
- i_wb_valid  in  1  retire strobe; one instruction leaves the pipe.
- i_wb_rd  in  REG_SELECT  register released by the retiring instruction.
- i_flush  in  1  taken branch/jump resolved; squash younger work.
- o_issue  out  1  fire = i_valid & o_ready.
- o_nop  out  1  = !o_issue; feeds the decoder NOP input (bubble).
- o_stall_hz  out  1  i_valid blocked by a scoreboard hazard (debug/perf).
- o_busy  out  1  state BUSY.
- o_pending  out  NUM_REG  scoreboard vector.

Behaviour:
- States: RUN, BUSY, FLUSH. Counter cnt is wide enough for max(MUL_LAT, DIV_LAT, FLUSH_CYCLES).
- Reset:
  - State RUN, cnt 0, o_pending all 0.
  - While i_rst is high: o_ready 0, o_issue 0, o_nop 1, o_stall_hz 0, o_busy 0.
  - Reset mid-BUSY or mid-FLUSH abandons the operation in the next cycle.
- Register 0 is never marked pending; operands equal to 0 never hazard.
- Hazard definition:
  - busy(r) = o_pending[r] & !(i_wb_valid & i_wb_rd == r). A same-cycle retire is forwarded.
  - hz = (i_rs1_en & busy(i_rs1)) | (i_rs2_en & busy(i_rs2)) | (i_rd_en & busy(i_rd)).
- o_ready = state==RUN & !hz & !i_flush. It is combinational, and i_valid must not depend on o_ready.
- o_stall_hz = i_valid & state==RUN & hz.
- Scoreboard update at the clock edge:
  - o_pending[i_wb_rd] is cleared on i_wb_valid.
  - o_pending[i_rd] is set on o_issue & i_rd_en & i_rd!=0.
  - Set wins over clear when both target the same register in the same cycle.
  - A retire of an unpending register is a no-op.
- Squashed instructions are still retired by downstream through i_wb_valid. The scoreboard is never mass-cleared by a flush.
- RUN:
  - o_issue with i_is_mul and MUL_LAT>1 -> BUSY, cnt = MUL_LAT-2.
  - o_issue with i_is_div and DIV_LAT>1 -> BUSY, cnt = DIV_LAT-2.
  - A latency of 1 stays in RUN.
  - Net effect: exactly LAT-1 stall cycles follow the issue cycle.
- BUSY: o_ready 0. If cnt==0 -> RUN, else cnt-1.
- FLUSH: o_ready 0. If cnt==0 -> RUN, else cnt-1.
- i_flush, from any state including BUSY and FLUSH:
  - Next state FLUSH with cnt = FLUSH_CYCLES-1, giving exactly FLUSH_CYCLES bubble cycles after the flush cycle.
  - No issue in the flush cycle itself.
  - Flush has priority over BUSY completion and over a concurrent MUL/DIV issue.
  - A flush during FLUSH restarts the count.
- Back-to-back issue: one instruction per cycle in RUN with no hazards; no turnaround cycle.

Test Plan:
- Reset, then issue ADD rd=5 with rs 1,2 -> o_issue=1 same cycle; o_pending[5]=1 next cycle. Next instruction reads rs1=5 -> o_ready=0, o_stall_hz=1, o_nop=1 until i_wb_valid with wb_rd=5. On the wb cycle itself, o_ready=1 (forward).
- Same-cycle issue of rd=7 and retire of wb_rd=7 -> o_pending[7]=1 afterwards. Issue with rd=0 -> o_pending stays 0.
- Issue DIV, DIV_LAT=8 -> o_busy=1 for 7 cycles, o_ready=0 throughout; next instruction issues on cycle 8. MUL with MUL_LAT=3 -> 2 stall cycles.
- i_flush while BUSY at cnt=4 -> no issue in the flush cycle; exactly 2 bubble cycles (FLUSH_CYCLES=2) with o_nop=1; RUN resumes on the 3rd cycle after the flush. Scoreboard is unchanged until retires arrive.
- Assert i_rst in the middle of FLUSH with o_pending=0x00000060 -> next cycle state RUN, o_pending=0, o_ready=0 while i_rst is held.
- WAW: issue rd=3, then a second write to rd=3 before retire -> stalled until the first retire of r3.
